// File: rtl/branch_pkg.sv
// ============================================================================
// Module : branch_pkg
// Brief  : Shared types and constants for the branch resolve tracker.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package branch_pkg;

    localparam int TAG_W = 8;

    // Predictor counter encoding, shared with the 2-bit saturating predictor
    localparam logic [1:0] ST_SNT = 2'b00;
    localparam logic [1:0] ST_WNT = 2'b01;
    localparam logic [1:0] ST_WT  = 2'b10;
    localparam logic [1:0] ST_ST  = 2'b11;

    typedef struct packed {
        logic             pred;
        logic [TAG_W-1:0] tag;
    } br_entry_t;

endpackage

`default_nettype wire

// File: rtl/tracker_fifo.sv
// ============================================================================
// Module : tracker_fifo
// Brief  : In-order queue of predicted branches with push/pop/clear and count.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tracker_fifo
    import branch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push_i,
    input  br_entry_t                  entry_i,
    input  logic                       pop_i,
    input  logic                       clear_i,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output br_entry_t                  head_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    br_entry_t         mem_q [DEPTH];
    logic [AW-1:0]     rd_q;
    logic [AW-1:0]     wr_q;
    logic [CW-1:0]     count_q;
    logic              w_full;
    logic              w_empty;
    logic              w_do_push;
    logic              w_do_pop;

    assign w_full    = (count_q == DEPTH[CW-1:0]);
    assign w_empty   = (count_q == '0);
    assign w_do_push = push_i & ~w_full;
    assign w_do_pop  = pop_i & ~w_empty;
    assign count_o   = count_q;
    assign head_o    = mem_q[rd_q];

    // Clear dominates; pointers return to 0 so the queue restarts cleanly
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q    <= '0;
            wr_q    <= '0;
            count_q <= '0;
        end else if (clear_i) begin
            rd_q    <= '0;
            wr_q    <= '0;
            count_q <= '0;
        end else begin
            if (w_do_push) wr_q <= wr_q + AW'(1);
            if (w_do_pop)  rd_q <= rd_q + AW'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push && !clear_i) mem_q[wr_q] <= entry_i;
    end

endmodule

`default_nettype wire

// File: rtl/branch_resolve_tracker.sv
// ============================================================================
// Module : branch_resolve_tracker
// Brief  : Requests predictions for fetched branches, queues them in order and
//          reports resolved outcomes / mispredict flushes back to the predictor.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module branch_resolve_tracker
    import branch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             br_fetch_i,
    input  logic [TAG_W-1:0] br_tag_i,
    output logic             fetch_stall_o,
    input  logic             br_resolve_i,
    input  logic             br_taken_i,
    output logic             pred_enable_o,
    output logic             pred_request_o,
    input  logic             pred_in_i,
    output logic             pred_result_o,
    output logic             pred_taken_o,
    output logic             fetch_pred_o,
    output logic             fetch_pred_vld_o,
    output logic             mispredict_o,
    output logic [TAG_W-1:0] mispredict_tag_o,
    output logic             resolve_err_o
);

    localparam int CW = $clog2(DEPTH+1);
    localparam logic [CW:0] C_DEPTH = DEPTH[CW:0];

    logic [CW-1:0]    w_count;
    br_entry_t        w_head;
    br_entry_t        w_entry;
    logic [CW:0]      w_occ;
    logic             w_flush;
    logic             w_push;
    logic             w_pop;

    logic             cap_pending_q, cap_pending_d;
    logic [TAG_W-1:0] tag_q,         tag_d;
    logic             pred_result_q, pred_result_d;
    logic             pred_taken_q,  pred_taken_d;
    logic             mispredict_q,  mispredict_d;
    logic [TAG_W-1:0] mis_tag_q,     mis_tag_d;
    logic             res_err_q,     res_err_d;

    // The registered mispredict pulse doubles as the flush cycle
    assign w_flush = mispredict_q;
    assign w_occ   = {1'b0, w_count} + {{CW{1'b0}}, cap_pending_q};

    assign fetch_stall_o    = w_flush | (w_occ >= C_DEPTH);
    assign pred_request_o   = br_fetch_i & ~fetch_stall_o;
    assign pred_enable_o    = 1'b1;
    assign w_push           = cap_pending_q & ~w_flush;
    assign w_pop            = br_resolve_i & (w_count != '0);
    assign fetch_pred_o     = w_push & pred_in_i;
    assign fetch_pred_vld_o = w_push;
    assign w_entry          = '{pred: pred_in_i, tag: tag_q};

    always_comb begin
        cap_pending_d = pred_request_o;
        tag_d         = pred_request_o ? br_tag_i : tag_q;
        pred_result_d = w_pop;
        pred_taken_d  = w_pop & br_taken_i;
        mispredict_d  = w_pop & (w_head.pred != br_taken_i);
        mis_tag_d     = mispredict_d ? w_head.tag : '0;
        res_err_d     = br_resolve_i & (w_count == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_pending_q <= 1'b0;
            tag_q         <= '0;
            pred_result_q <= 1'b0;
            pred_taken_q  <= 1'b0;
            mispredict_q  <= 1'b0;
            mis_tag_q     <= '0;
            res_err_q     <= 1'b0;
        end else begin
            cap_pending_q <= cap_pending_d;
            tag_q         <= tag_d;
            pred_result_q <= pred_result_d;
            pred_taken_q  <= pred_taken_d;
            mispredict_q  <= mispredict_d;
            mis_tag_q     <= mis_tag_d;
            res_err_q     <= res_err_d;
        end
    end

    assign pred_result_o    = pred_result_q;
    assign pred_taken_o     = pred_taken_q;
    assign mispredict_o     = mispredict_q;
    assign mispredict_tag_o = mis_tag_q;
    assign resolve_err_o    = res_err_q;

    tracker_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (w_push),
        .entry_i (w_entry),
        .pop_i   (w_pop),
        .clear_i (w_flush),
        .count_o (w_count),
        .head_o  (w_head)
    );

endmodule

`default_nettype wire

// File: tb/tb_branch_resolve_tracker.sv
// ============================================================================
// Module : tb_branch_resolve_tracker
// Brief  : Directed self-checking bench for branch_resolve_tracker.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_branch_resolve_tracker;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       br_fetch, br_resolve, br_taken, pred_in;
    logic [7:0] br_tag;
    logic       fetch_stall, pred_enable, pred_request, pred_result, pred_taken;
    logic       fetch_pred, fetch_pred_vld, mispredict, resolve_err;
    logic [7:0] mispredict_tag;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    branch_resolve_tracker #(.DEPTH(4)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .br_fetch_i       (br_fetch),
        .br_tag_i         (br_tag),
        .fetch_stall_o    (fetch_stall),
        .br_resolve_i     (br_resolve),
        .br_taken_i       (br_taken),
        .pred_enable_o    (pred_enable),
        .pred_request_o   (pred_request),
        .pred_in_i        (pred_in),
        .pred_result_o    (pred_result),
        .pred_taken_o     (pred_taken),
        .fetch_pred_o     (fetch_pred),
        .fetch_pred_vld_o (fetch_pred_vld),
        .mispredict_o     (mispredict),
        .mispredict_tag_o (mispredict_tag),
        .resolve_err_o    (resolve_err)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h @%0t", tag, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic f, input logic [7:0] t, input logic p);
        br_fetch = f;
        br_tag   = t;
        pred_in  = p;
    endtask

    task automatic resolve(input logic r, input logic t);
        br_resolve = r;
        br_taken   = t;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        fetch(0, 8'h00, 0);
        resolve(0, 0);
        #3;
        check("rst_stall",   32'(fetch_stall),    0);
        check("rst_enable",  32'(pred_enable),    1);
        check("rst_request", 32'(pred_request),   0);
        check("rst_vld",     32'(fetch_pred_vld), 0);
        check("rst_mis",     32'(mispredict),     0);
        check("rst_err",     32'(resolve_err),    0);
        check("rst_result",  32'(pred_result),    0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick();

        // 1: request then capture
        fetch(1, 8'h11, 0); #1;
        check("t1_request", 32'(pred_request), 1);
        tick();
        fetch(0, 8'h00, 1); #1;
        check("t1_fpred", 32'(fetch_pred),     1);
        check("t1_vld",   32'(fetch_pred_vld), 1);
        tick();
        pred_in = 0; #1;
        check("t1_count", 32'(dut.u_fifo.count_q), 1);
        check("t1_vld_off", 32'(fetch_pred_vld), 0);

        // 2: correct prediction resolve
        resolve(1, 1); #1;
        tick();
        resolve(0, 0); #1;
        check("t2_result", 32'(pred_result), 1);
        check("t2_taken",  32'(pred_taken),  1);
        check("t2_mis",    32'(mispredict),  0);
        check("t2_count",  32'(dut.u_fifo.count_q), 0);
        tick();

        // 3: three queued, first mispredicts
        fetch(1, 8'h01, 0); #1; tick();
        fetch(1, 8'h02, 1); #1; tick();
        fetch(1, 8'h03, 1); #1; tick();
        fetch(0, 8'h00, 0); #1; tick();
        check("t3_count3", 32'(dut.u_fifo.count_q), 3);
        resolve(1, 0); #1; tick();
        resolve(0, 0);
        fetch(1, 8'h44, 0); #1;
        check("t3_mis",     32'(mispredict),     1);
        check("t3_mistag",  32'(mispredict_tag), 32'h01);
        check("t3_stall",   32'(fetch_stall),    1);
        check("t3_noreq",   32'(pred_request),   0);
        check("t3_result",  32'(pred_result),    1);
        check("t3_taken",   32'(pred_taken),     0);
        tick();
        fetch(0, 8'h00, 0); #1;
        check("t3_count0",  32'(dut.u_fifo.count_q), 0);
        check("t3_mis_off", 32'(mispredict),     0);
        check("t3_unstall", 32'(fetch_stall),    0);

        // 4: fill, stall, simultaneous push/pop, pointer wrap
        fetch(1, 8'h21, 0); #1; tick();
        fetch(1, 8'h22, 1); #1; tick();
        fetch(1, 8'h23, 0); #1; tick();
        fetch(1, 8'h24, 1); #1;
        check("t4_req4", 32'(pred_request), 1);
        tick();
        fetch(1, 8'h99, 0); #1;
        check("t4_stall_occ", 32'(fetch_stall),  1);
        check("t4_noreq_occ", 32'(pred_request), 0);
        tick();
        fetch(1, 8'h99, 0);
        resolve(1, 1); #1;
        check("t4_count4",    32'(dut.u_fifo.count_q), 4);
        check("t4_stall_full",32'(fetch_stall),  1);
        check("t4_noreq_full",32'(pred_request), 0);
        tick();
        resolve(0, 0);
        fetch(1, 8'h25, 0); #1;
        check("t4_res21",   32'(pred_result), 1);
        check("t4_mis21",   32'(mispredict),  0);
        check("t4_count3",  32'(dut.u_fifo.count_q), 3);
        check("t4_req25",   32'(pred_request), 1);
        tick();
        fetch(0, 8'h00, 1);
        resolve(1, 0); #1;
        check("t4_fpred25", 32'(fetch_pred),     1);
        check("t4_vld25",   32'(fetch_pred_vld), 1);
        check("t4_stall_cap", 32'(fetch_stall),  1);
        tick();
        fetch(0, 8'h00, 0);
        resolve(1, 1); #1;
        check("t4_pushpop", 32'(dut.u_fifo.count_q), 3);
        check("t4_mis22",   32'(mispredict), 0);
        check("t4_tk22",    32'(pred_taken), 0);
        check("t4_wrptr",   32'(dut.u_fifo.wr_q), 1);
        check("t4_rdptr",   32'(dut.u_fifo.rd_q), 2);
        tick();
        resolve(1, 0); #1;
        check("t4_mis23", 32'(mispredict), 0);
        tick();
        resolve(1, 0); #1;
        check("t4_mis24", 32'(mispredict), 0);
        tick();
        resolve(0, 0); #1;
        check("t4_mis25",    32'(mispredict),     1);
        check("t4_mistag25", 32'(mispredict_tag), 32'h25);
        tick();

        // 5: resolve with empty queue
        resolve(1, 1); #1;
        tick();
        resolve(0, 0); #1;
        check("t5_err",    32'(resolve_err), 1);
        check("t5_result", 32'(pred_result), 0);
        tick();
        check("t5_err_off", 32'(resolve_err), 0);

        // 6: async reset with entries and a pending capture
        fetch(1, 8'h31, 0); #1; tick();
        fetch(1, 8'h32, 1); #1; tick();
        fetch(1, 8'h33, 1); #1; tick();
        fetch(1, 8'h34, 1);
        resolve(1, 1); #1;
        check("t6_req34", 32'(pred_request), 1);
        tick();
        fetch(0, 8'h00, 1);
        resolve(0, 0); #1;
        check("t6_count2", 32'(dut.u_fifo.count_q), 2);
        check("t6_result", 32'(pred_result),    1);
        check("t6_vld",    32'(fetch_pred_vld), 1);
        rst_n = 1'b0; #1;
        check("t6_rst_count",  32'(dut.u_fifo.count_q), 0);
        check("t6_rst_result", 32'(pred_result),    0);
        check("t6_rst_vld",    32'(fetch_pred_vld), 0);
        check("t6_rst_fpred",  32'(fetch_pred),     0);
        check("t6_rst_enable", 32'(pred_enable),    1);
        tick();
        rst_n = 1'b1;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
